// File: rtl/cvt_9to16_if.sv
// Bus bundle for the 9-bit to 16-bit packetised bit-stream converter.
interface cvt_9to16_if;
  localparam int unsigned IN_W     = 9;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned IN_VB_W  = 4;
  localparam int unsigned OUT_VB_W = 5;

  logic [IN_W-1:0]     data_in;
  logic                data_in_valid;
  logic                data_in_sop;
  logic                data_in_eop;
  logic [IN_VB_W-1:0]  data_in_valid_bits;
  logic [OUT_W-1:0]    data_out;
  logic                data_out_valid;
  logic [OUT_VB_W-1:0] data_out_valid_bits;

  // Producer/consumer side: drives the narrow stream, observes packed words.
  modport master (
    output data_in, data_in_valid, data_in_sop, data_in_eop, data_in_valid_bits,
    input  data_out, data_out_valid, data_out_valid_bits
  );

  // Converter side.
  modport slave (
    input  data_in, data_in_valid, data_in_sop, data_in_eop, data_in_valid_bits,
    output data_out, data_out_valid, data_out_valid_bits
  );
endinterface

// File: rtl/cvt_9to16.sv
// Packs 0..9-bit input words into 16-bit output words, flushing partial
// words at end of packet with an explicit valid-bit count.
module cvt_9to16 #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  cvt_9to16_if.slave   bus_s
);

  localparam int unsigned ACC_W = OUT_W + IN_W - 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned NB_W  = 4;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dval_q, dval_d;
  logic [CNT_W-1:0] dvb_q, dvb_d;

  logic [NB_W-1:0]  n_c;
  logic [IN_W-1:0]  in_bits_c;
  logic [ACC_W-1:0] base_acc_c;
  logic [CNT_W-1:0] base_cnt_c;
  logic [ACC_W-1:0] merged_c;
  logic [CNT_W-1:0] total_c;

  // Clamp the bit count, mask unused input bits and append at position cnt.
  always_comb begin
    if (!bus_s.data_in_valid) begin
      n_c = '0;
    end else if (bus_s.data_in_valid_bits > NB_W'(IN_W)) begin
      n_c = NB_W'(IN_W);
    end else begin
      n_c = bus_s.data_in_valid_bits;
    end
    in_bits_c  = bus_s.data_in & IN_W'((10'd1 << n_c) - 10'd1);
    base_acc_c = bus_s.data_in_sop ? '0 : acc_q;
    base_cnt_c = bus_s.data_in_sop ? '0 : cnt_q;
    merged_c   = base_acc_c | (ACC_W'(in_bits_c) << base_cnt_c);
    total_c    = base_cnt_c + CNT_W'(n_c);
  end

  // Next state: residue flush takes priority, then full-word emit, then eop.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    dout_d  = '0;
    dval_d  = 1'b0;
    dvb_d   = '0;
    if (flush_q) begin
      dval_d  = 1'b1;
      dout_d  = OUT_W'(acc_q);
      dvb_d   = cnt_q;
      acc_d   = ACC_W'(in_bits_c);
      cnt_d   = CNT_W'(n_c);
      flush_d = bus_s.data_in_valid && bus_s.data_in_eop && (n_c != '0);
    end else if (bus_s.data_in_valid) begin
      if (total_c >= CNT_W'(OUT_W)) begin
        dval_d  = 1'b1;
        dout_d  = merged_c[OUT_W-1:0];
        dvb_d   = CNT_W'(OUT_W);
        acc_d   = merged_c >> OUT_W;
        cnt_d   = total_c - CNT_W'(OUT_W);
        flush_d = bus_s.data_in_eop && (total_c != CNT_W'(OUT_W));
      end else if (bus_s.data_in_eop) begin
        acc_d = '0;
        cnt_d = '0;
        if (total_c != '0) begin
          dval_d = 1'b1;
          dout_d = merged_c[OUT_W-1:0];
          dvb_d  = total_c;
        end
      end else begin
        acc_d = merged_c;
        cnt_d = total_c;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      dvb_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      dvb_q   <= dvb_d;
    end
  end

  assign bus_s.data_out            = dout_q;
  assign bus_s.data_out_valid      = dval_q;
  assign bus_s.data_out_valid_bits = dvb_q;

endmodule

// File: tb/tb_cvt_9to16.sv
// Self-checking bench for cvt_9to16: bit-queue reference model plus
// literal expectations for hand-worked packets.
module tb_cvt_9to16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cvt_9to16_if bus ();

  cvt_9to16 dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus_s (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: pending stream bits, oldest first.
  bit   bq[$];
  bit   fp = 1'b0;
  logic        e_v  = 1'b0;
  logic [15:0] e_d  = '0;
  logic [4:0]  e_vb = '0;

  logic        chk_en = 1'b0;
  logic        lit_en = 1'b0;
  logic        l_v    = 1'b0;
  logic [15:0] l_d    = '0;
  logic [4:0]  l_vb   = '0;

  task automatic emit(input int k);
    e_v  = 1'b1;
    e_vb = 5'(k);
    e_d  = '0;
    for (int i = 0; i < k; i++) e_d[i] = bq.pop_front();
  endtask

  // Expected output after the coming edge, derived from the current inputs.
  task automatic model_step();
    int n;
    bit nb[$];
    e_v = 1'b0; e_d = '0; e_vb = '0;
    if (!rstn) begin
      bq.delete();
      fp = 1'b0;
      return;
    end
    n = 0;
    if (bus.data_in_valid) n = (int'(bus.data_in_valid_bits) > 9) ? 9 : int'(bus.data_in_valid_bits);
    for (int i = 0; i < n; i++) nb.push_back(bus.data_in[i]);
    if (fp) begin
      emit(bq.size());
      bq = nb;
      fp = bus.data_in_eop && (n > 0);
    end else if (bus.data_in_valid) begin
      if (bus.data_in_sop) bq.delete();
      foreach (nb[i]) bq.push_back(nb[i]);
      if (bq.size() >= 16) begin
        emit(16);
        fp = bus.data_in_eop && (bq.size() > 0);
      end else if (bus.data_in_eop) begin
        if (bq.size() > 0) emit(bq.size());
        bq.delete();
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model (and literals when armed) each cycle.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_valid", 16'(bus.data_out_valid), 16'(e_v));
      chk("model_data", bus.data_out, e_d);
      chk("model_vbits", 16'(bus.data_out_valid_bits), 16'(e_vb));
      if (lit_en) begin
        chk("lit_valid", 16'(bus.data_out_valid), 16'(l_v));
        chk("lit_data", bus.data_out, l_d);
        chk("lit_vbits", 16'(bus.data_out_valid_bits), 16'(l_vb));
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic s, input logic e,
                     input logic [3:0] vb, input logic [8:0] d,
                     input logic lc, input logic lv, input logic [15:0] ld,
                     input logic [4:0] lvb);
    @(negedge clk);
    rstn                   = r;
    bus.data_in_valid      = v;
    bus.data_in_sop        = s;
    bus.data_in_eop        = e;
    bus.data_in_valid_bits = vb;
    bus.data_in            = d;
    model_step();
    lit_en = lc;
    l_v    = lv;
    l_d    = ld;
    l_vb   = lvb;
    chk_en = 1'b1;
  endtask

  task automatic idle_lit(input logic lv, input logic [15:0] ld, input logic [4:0] lvb);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b1, lv, ld, lvb);
  endtask

  initial begin
    bus.data_in            = '0;
    bus.data_in_valid      = 1'b0;
    bus.data_in_sop        = 1'b0;
    bus.data_in_eop        = 1'b0;
    bus.data_in_valid_bits = '0;

    // Reset, then idle with no output.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b1, 1'b0, 16'h0000, 5'd0);
    idle_lit(1'b0, 16'h0000, 5'd0);
    idle_lit(1'b0, 16'h0000, 5'd0);

    // Two-word packet: 18 bits, split into 16 + 2.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 9'h155, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 9'h0AA, 1'b1, 1'b1, 16'h5555, 5'd16);
    idle_lit(1'b1, 16'h0001, 5'd2);
    idle_lit(1'b0, 16'h0000, 5'd0);

    // Short final word: 17 bits.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 9'h1FF, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd8, 9'h0FF, 1'b1, 1'b1, 16'hFFFF, 5'd16);
    idle_lit(1'b1, 16'h0001, 5'd1);

    // Single-word packet, bit 8 masked.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 9'h1FF, 1'b1, 1'b1, 16'h00FF, 5'd8);
    idle_lit(1'b0, 16'h0000, 5'd0);

    // Back-to-back: new sop arrives in the flush cycle.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 9'h155, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 9'h0AA, 1'b1, 1'b1, 16'h5555, 5'd16);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 9'h1FF, 1'b1, 1'b1, 16'h0001, 5'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 9'h07F, 1'b1, 1'b1, 16'hFFFF, 5'd16);
    idle_lit(1'b0, 16'h0000, 5'd0);

    // Masking: four 4-bit words make exactly one full word; vb 12 clamps to 9.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 9'h1FF, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 9'h1FF, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 9'h1FF, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 9'h1FF, 1'b1, 1'b1, 16'hFFFF, 5'd16);
    idle_lit(1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 9'h1FF, 1'b1, 1'b1, 16'h01FF, 5'd9);

    // Zero-bit eop word still terminates the packet.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 9'h015, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 9'h1FF, 1'b1, 1'b1, 16'h0015, 5'd5);

    // Unterminated residue dropped by a new sop.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 9'h0AB, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 9'h005, 1'b1, 1'b1, 16'h0005, 5'd3);

    // eop without valid is ignored.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 9'h02A, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 9'h1FF, 1'b1, 1'b0, 16'h0000, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 9'h003, 1'b1, 1'b1, 16'h00EA, 5'd8);

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      cyc(logic'($urandom_range(0, 299) != 0),
          logic'($urandom_range(0, 9) < 7),
          logic'($urandom_range(0, 5) == 0),
          logic'($urandom_range(0, 4) == 0),
          4'($urandom_range(0, 15)),
          9'($urandom),
          1'b0, 1'b0, 16'h0000, 5'd0);
    end

    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b0, 1'b0, 16'h0000, 5'd0);
    @(negedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
